// File: rtl/channel_frame_packer_if.sv
// rtl/channel_frame_packer_if.sv - channel FIFO head/pop and AXI-stream byte output bundle
interface channel_frame_packer_if;
  logic [119:0] channel_data;
  logic         channel_fifo_empty;
  logic         channel_data_read;
  logic [7:0]   tx_axis_fifo_tdata;
  logic         tx_axis_fifo_tvalid;
  logic         tx_axis_fifo_tlast;
  logic         tx_axis_fifo_tready;

  modport master (
    input  channel_data, channel_fifo_empty, tx_axis_fifo_tready,
    output channel_data_read, tx_axis_fifo_tdata, tx_axis_fifo_tvalid, tx_axis_fifo_tlast
  );

  modport slave (
    output channel_data, channel_fifo_empty, tx_axis_fifo_tready,
    input  channel_data_read, tx_axis_fifo_tdata, tx_axis_fifo_tvalid, tx_axis_fifo_tlast
  );
endinterface

// File: rtl/channel_frame_packer.sv
// rtl/channel_frame_packer.sv - packs 120-bit channel words into Ethernet-style byte frames
// Optional macro FRAME_CHECKSUM_EN adds an XOR-of-payload byte ahead of the padding.
module channel_frame_packer #(
  parameter int          MAX_WORDS = 64,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic [47:0] i_d_mac_add,
  input  logic [47:0] i_s_mac_add,
  input  logic [7:0]  i_trigger_index,
  input  logic [2:0]  i_channel_id,
  output logic [15:0] o_frame_count,
  channel_frame_packer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_NEXT,
    S_PAD,
    S_TRAILER
`ifdef FRAME_CHECKSUM_EN
    , S_CHECKSUM
`endif
  } state_t;

  localparam logic [7:0]  MAX_W    = 8'(MAX_WORDS);
  localparam logic [15:0] PAD_UPTO = 16'd59;

  state_t      r_state;
  logic [4:0]  r_idx;
  logic [15:0] r_total;
  logic [7:0]  r_words;
  logic [47:0] r_dmac;
  logic [47:0] r_smac;
  logic [7:0]  r_trig;
  logic [2:0]  r_chid;
  logic [7:0]  r_tdata;
  logic        r_tvalid;
  logic        r_tlast;
  logic [15:0] r_frame_count;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]  r_xsum;
`endif

  logic w_accept;
  logic w_pop;

  assign w_accept = r_tvalid & bus.tx_axis_fifo_tready;
  // Pop combinationally with the last payload byte so NEXT already sees the new FIFO head.
  assign w_pop    = (r_state == S_PAYLOAD) && (r_idx == 5'd14) && w_accept;

  assign bus.channel_data_read   = w_pop;
  assign bus.tx_axis_fifo_tdata  = r_tdata;
  assign bus.tx_axis_fifo_tvalid = r_tvalid;
  assign bus.tx_axis_fifo_tlast  = r_tlast;
  assign o_frame_count           = r_frame_count;

  function automatic logic [7:0] payload_byte(input logic [119:0] d, input logic [4:0] idx);
    logic [119:0] s;
    s = d << (8 * idx);
    return s[119:112];
  endfunction

  function automatic logic [7:0] header_byte(input logic [4:0] idx);
    logic [7:0] b;
    case (idx)
      5'd0:    b = r_dmac[47:40];
      5'd1:    b = r_dmac[39:32];
      5'd2:    b = r_dmac[31:24];
      5'd3:    b = r_dmac[23:16];
      5'd4:    b = r_dmac[15:8];
      5'd5:    b = r_dmac[7:0];
      5'd6:    b = r_smac[47:40];
      5'd7:    b = r_smac[39:32];
      5'd8:    b = r_smac[31:24];
      5'd9:    b = r_smac[23:16];
      5'd10:   b = r_smac[15:8];
      5'd11:   b = r_smac[7:0];
      5'd12:   b = ETHERTYPE[15:8];
      5'd13:   b = ETHERTYPE[7:0];
      5'd14:   b = {5'b0, r_chid};
      5'd15:   b = r_trig;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_total       <= '0;
      r_words       <= '0;
      r_dmac        <= '0;
      r_smac        <= '0;
      r_trig        <= '0;
      r_chid        <= '0;
      r_tdata       <= 8'h00;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_frame_count <= '0;
`ifdef FRAME_CHECKSUM_EN
      r_xsum        <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_enable && !bus.channel_fifo_empty) begin
            r_dmac   <= i_d_mac_add;
            r_smac   <= i_s_mac_add;
            r_trig   <= i_trigger_index;
            r_chid   <= i_channel_id;
            r_idx    <= '0;
            r_total  <= '0;
            r_words  <= '0;
`ifdef FRAME_CHECKSUM_EN
            r_xsum   <= '0;
`endif
            r_tdata  <= i_d_mac_add[47:40];
            r_tvalid <= 1'b1;
            r_tlast  <= 1'b0;
            r_state  <= S_HEADER;
          end
        end

        S_HEADER: begin
          if (w_accept) begin
            r_total <= r_total + 16'd1;
            if (r_idx == 5'd16) begin
              r_idx   <= '0;
              r_tdata <= payload_byte(bus.channel_data, 5'd0);
              r_state <= S_PAYLOAD;
            end else begin
              r_idx   <= r_idx + 5'd1;
              r_tdata <= header_byte(r_idx + 5'd1);
            end
          end
        end

        S_PAYLOAD: begin
          if (w_accept) begin
            r_total <= r_total + 16'd1;
`ifdef FRAME_CHECKSUM_EN
            r_xsum  <= r_xsum ^ r_tdata;
`endif
            if (r_idx == 5'd14) begin
              r_idx    <= '0;
              r_words  <= r_words + 8'd1;
              r_tvalid <= 1'b0;
              r_state  <= S_NEXT;
            end else begin
              r_idx   <= r_idx + 5'd1;
              r_tdata <= payload_byte(bus.channel_data, r_idx + 5'd1);
            end
          end
        end

        S_NEXT: begin
          r_tvalid <= 1'b1;
          if ((r_words < MAX_W) && !bus.channel_fifo_empty) begin
            r_tdata <= payload_byte(bus.channel_data, 5'd0);
            r_state <= S_PAYLOAD;
          end else begin
`ifdef FRAME_CHECKSUM_EN
            r_tdata <= r_xsum;
            r_state <= S_CHECKSUM;
`else
            if (r_total < PAD_UPTO) begin
              r_tdata <= 8'h00;
              r_state <= S_PAD;
            end else begin
              r_tdata <= r_words;
              r_tlast <= 1'b1;
              r_state <= S_TRAILER;
            end
`endif
          end
        end

`ifdef FRAME_CHECKSUM_EN
        S_CHECKSUM: begin
          if (w_accept) begin
            r_total <= r_total + 16'd1;
            if ((r_total + 16'd1) < PAD_UPTO) begin
              r_tdata <= 8'h00;
              r_state <= S_PAD;
            end else begin
              r_tdata <= r_words;
              r_tlast <= 1'b1;
              r_state <= S_TRAILER;
            end
          end
        end
`endif

        S_PAD: begin
          if (w_accept) begin
            r_total <= r_total + 16'd1;
            if ((r_total + 16'd1) >= PAD_UPTO) begin
              r_tdata <= r_words;
              r_tlast <= 1'b1;
              r_state <= S_TRAILER;
            end
          end
        end

        S_TRAILER: begin
          if (w_accept) begin
            r_tvalid      <= 1'b0;
            r_tlast       <= 1'b0;
            r_tdata       <= 8'h00;
            r_frame_count <= r_frame_count + 16'd1;
            r_state       <= S_IDLE;
          end
        end

        default: begin
          r_tvalid <= 1'b0;
          r_tlast  <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
